// File: rtl/mem_access_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_unit_pkg
// Purpose : Shared encodings for the MEM-stage access unit. This package holds
//           the load/store funct3 codes, the enable-bit positions inside the
//           decoded mem_read/mem_write fields, the access-size field and the
//           FSM state encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
package mem_access_unit_pkg;

  // Enable-bit positions inside the decoded control fields.
  localparam int LOAD_EN_BIT  = 3;
  localparam int STORE_EN_BIT = 2;

  // Load funct3 codes.
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3[1:0] codes.
  localparam logic [1:0] F3_SB = 2'b00;
  localparam logic [1:0] F3_SH = 2'b01;
  localparam logic [1:0] F3_SW = 2'b10;

  // funct3[1:0] doubles as the access size for both loads and stores.
  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  // Byte-lane enables of an access of the given size starting at lane.
  function automatic logic [3:0] lane_mask(input logic [1:0] size,
                                           input logic [1:0] lane);
    logic [3:0] mask;
    mask = 4'b1111;
    case (size)
      SIZE_BYTE: mask = 4'b0001 << lane;
      SIZE_HALF: mask = 4'b0011 << lane;
      default:   mask = 4'b1111;
    endcase
    return mask;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_access_unit_load_extend.sv
`default_nettype none
// ============================================================================
// Module  : load_extend
// Purpose : Selects the addressed byte/halfword of a memory word and sign- or
//           zero-extends it. The block is purely combinational and is shared
//           with the forwarding logic.
// Ports   : word   in  32  raw memory word
//           lane   in  2   byte offset of the access (addr[1:0])
//           funct3 in  3   load funct3 (LB/LH/LW/LBU/LHU)
//           result out 32  extended load value (0 for undefined funct3)
// Rev     : 1.0  initial release
// ============================================================================
module load_extend
  import mem_access_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    // Halfword accesses are aligned, so only lane[1] picks the half.
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  always_comb begin
    case (funct3)
      F3_LB:   result = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result = {24'h0, byte_sel};
      F3_LH:   result = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result = {16'h0, half_sel};
      F3_LW:   result = word;
      default: result = 32'h0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : mem_access_unit
// Purpose : MEM-stage load/store engine. It turns one decoded load or store
//           into a word-aligned request/ack handshake with data memory. It
//           stalls the pipeline while the access is outstanding and returns
//           formatted load data with a one-cycle done pulse.
// Ports   : clk, reset (async, active-high)
//           mem_read[3:0]  load enable + funct3
//           mem_write[2:0] store enable + funct3[1:0]
//           addr, wdata    effective address / store data
//           rdata, done, mem_fault, busy_wait  pipeline-side results
//           dmem_read, dmem_write, dmem_addr, dmem_byte_en, dmem_wdata,
//           dmem_rdata, dmem_ack               data-memory handshake
// Rev     : 1.0  initial release
// ============================================================================
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [3:0]        mem_read,
  input  logic [2:0]        mem_write,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              mem_fault,
  output logic              busy_wait,
  output logic              dmem_read,
  output logic              dmem_write,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_byte_en,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack
);

  localparam int CNT_W      = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  state_t state, state_next;

  // Request decode (IDLE only).
  logic        req_store, req_load, req;
  logic [2:0]  req_f3;
  logic [1:0]  req_size;
  logic        illegal, misaligned, accept_fault;
  logic [3:0]  req_be;
  logic [31:0] req_wdata;

  // Registered access.
  logic             op_store_r;
  logic [2:0]       f3_r;
  logic [1:0]       lane_r;
  logic             fault_r;
  logic [CNT_W-1:0] cnt_r;

  logic [31:0] load_ext;
  logic        timeout_hit;

  // Store takes priority when both enables are set.
  assign req_store = mem_write[STORE_EN_BIT];
  assign req_load  = mem_read[LOAD_EN_BIT] & ~req_store;
  assign req       = req_store | req_load;
  assign req_f3    = req_store ? {1'b0, mem_write[1:0]} : mem_read[2:0];
  assign req_size  = req_f3[1:0];

  // Size code 11 is illegal for both kinds; loads additionally reject 110.
  assign illegal      = (req_size == 2'b11) | (~req_store & (req_f3 == 3'b110));
  assign misaligned   = ((req_size == SIZE_HALF) & addr[0]) |
                        ((req_size == SIZE_WORD) & (addr[1:0] != 2'b00));
  assign accept_fault = illegal | misaligned;

  assign req_be = req_store ? lane_mask(req_size, addr[1:0]) : 4'b1111;

  always_comb begin
    case (req_size)
      SIZE_BYTE: req_wdata = {4{wdata[7:0]}};
      SIZE_HALF: req_wdata = {2{wdata[15:0]}};
      default:   req_wdata = wdata;
    endcase
  end

  assign timeout_hit = TIMEOUT_EN && (cnt_r == CNT_W'(TIMEOUT));

  load_extend u_load_extend (
    .word   (dmem_rdata),
    .lane   (lane_r),
    .funct3 (f3_r),
    .result (load_ext)
  );

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_next;
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (req) state_next = accept_fault ? ST_DONE : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (dmem_ack || timeout_hit) state_next = ST_DONE;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy_wait  = 1'b0;
    dmem_read  = 1'b0;
    dmem_write = 1'b0;
    done       = 1'b0;
    mem_fault  = 1'b0;
    unique case (state)
      // The request stalls the pipeline in its first cycle already. Reset
      // forces the stall off even if the decode still shows a memory op.
      ST_IDLE: busy_wait = req & ~reset;
      ST_ACCESS: begin
        busy_wait  = 1'b1;
        dmem_read  = ~op_store_r;
        dmem_write = op_store_r;
      end
      ST_DONE: begin
        done      = 1'b1;
        mem_fault = fault_r;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Access registers, timeout counter and load result
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_store_r   <= 1'b0;
      f3_r         <= 3'b000;
      lane_r       <= 2'b00;
      fault_r      <= 1'b0;
      cnt_r        <= '0;
      rdata        <= 32'h0;
      dmem_addr    <= '0;
      dmem_byte_en <= 4'b0000;
      dmem_wdata   <= 32'h0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          cnt_r <= '0;
          if (req) begin
            op_store_r   <= req_store;
            f3_r         <= req_f3;
            lane_r       <= addr[1:0];
            fault_r      <= accept_fault;
            dmem_addr    <= {addr[ADDR_W-1:2], 2'b00};
            dmem_byte_en <= req_be;
            dmem_wdata   <= req_wdata;
            // A rejected access completes as a fault with a zero result.
            if (accept_fault) rdata <= 32'h0;
          end
        end
        ST_ACCESS: begin
          cnt_r <= cnt_r + 1'b1;
          if (dmem_ack) begin
            if (!op_store_r) rdata <= load_ext;
          end else if (timeout_hit) begin
            fault_r <= 1'b1;
            rdata   <= 32'h0;
          end
        end
        default: cnt_r <= '0;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mem_access_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_mem_access_unit
// Purpose : Self-checking bench for mem_access_unit. Directed scenarios are
//           followed by randomized loads/stores checked against a behavioural
//           reference model.
// Rev     : 1.0  initial release
// ============================================================================
module tb_mem_access_unit;

  localparam int TMO = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  mem_read;
  logic [2:0]  mem_write;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        done;
  logic        mem_fault;
  logic        busy_wait;
  logic        dmem_read;
  logic        dmem_write;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_byte_en;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_rdata;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_W(32), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .addr         (addr),
    .wdata        (wdata),
    .rdata        (rdata),
    .done         (done),
    .mem_fault    (mem_fault),
    .busy_wait    (busy_wait),
    .dmem_read    (dmem_read),
    .dmem_write   (dmem_write),
    .dmem_addr    (dmem_addr),
    .dmem_byte_en (dmem_byte_en),
    .dmem_wdata   (dmem_wdata),
    .dmem_rdata   (dmem_rdata),
    .dmem_ack     (dmem_ack)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks happen 3 later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [1:0] a,
                                           input logic [2:0] f3);
    logic [31:0] sh;
    case (f3)
      3'b000: begin sh = w >> (8 * a);      return 32'($signed(sh[7:0]));  end
      3'b100: begin sh = w >> (8 * a);      return {24'h0, sh[7:0]};       end
      3'b001: begin sh = w >> (16 * a[1]);  return 32'($signed(sh[15:0])); end
      3'b101: begin sh = w >> (16 * a[1]);  return {16'h0, sh[15:0]};      end
      default: return w;
    endcase
  endfunction

  function automatic bit ref_fault(input bit st, input logic [2:0] f3, input logic [1:0] a);
    int n;
    if (st) begin
      if (f3[1:0] == 2'b11) return 1'b1;
    end else if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) begin
      return 1'b1;
    end
    n = 1 << f3[1:0];
    return (int'(a) % n) != 0;
  endfunction

  function automatic void ref_store(input logic [1:0] sz, input logic [1:0] a,
                                    input logic [31:0] wd,
                                    output logic [3:0] be, output logic [31:0] d);
    int n;
    int la;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    la = int'(a);
    for (int i = 0; i < 4; i++) begin
      be[i]        = (i >= la) && (i < la + n);
      d[8*i +: 8]  = wd[8*(i % n) +: 8];
    end
  endfunction

  // One full transaction starting at the request cycle. k is the cycle
  // (relative to the request) in which ack is offered; large k never acks.
  task automatic run_txn(input bit st, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] wd, input logic [31:0] mw, input int k);
    bit          fs;
    bit          tmo;
    int          dcyc;
    logic [3:0]  be;
    logic [31:0] wrep;
    fs = ref_fault(st, f3, a[1:0]);
    ref_store(f3[1:0], a[1:0], wd, be, wrep);
    if (st) begin
      mem_write = {1'b1, f3[1:0]};
      mem_read  = {1'($urandom_range(0, 1)), 3'($urandom)};
    end else begin
      mem_read  = {1'b1, f3};
      mem_write = {1'b0, 2'($urandom)};
    end
    addr       = a;
    wdata      = wd;
    dmem_ack   = 1'($urandom_range(0, 1));
    dmem_rdata = $urandom;
    #3;
    chk("req_busy", busy_wait, 1);
    chk("req_done", done, 0);
    chk("req_noreq", {dmem_read, dmem_write}, 0);
    if (fs) begin
      next_cycle();
      #3;
      exp_rdata = 32'h0;
      chk("flt_done", done, 1);
      chk("flt_fault", mem_fault, 1);
      chk("flt_busy", busy_wait, 0);
      chk("flt_noreq", {dmem_read, dmem_write}, 0);
      chk("flt_rdata", rdata, exp_rdata);
    end else begin
      tmo  = (k > TMO + 1);
      dcyc = tmo ? TMO + 2 : k + 1;
      for (int c = 1; c < dcyc; c++) begin
        next_cycle();
        dmem_ack   = (c == k);
        dmem_rdata = (c == k) ? mw : $urandom;
        #3;
        chk("acc_read", dmem_read, !st);
        chk("acc_write", dmem_write, st);
        chk("acc_addr", dmem_addr, {a[31:2], 2'b00});
        chk("acc_be", dmem_byte_en, st ? be : 4'hF);
        if (st) chk("acc_wdata", dmem_wdata, wrep);
        chk("acc_busy", busy_wait, 1);
        chk("acc_done", done, 0);
      end
      next_cycle();
      dmem_ack   = 1'($urandom_range(0, 1));
      dmem_rdata = $urandom;
      #3;
      if (tmo) exp_rdata = 32'h0;
      else if (!st) exp_rdata = ref_load(mw, a[1:0], f3);
      chk("dn_done", done, 1);
      chk("dn_fault", mem_fault, tmo);
      chk("dn_busy", busy_wait, 0);
      chk("dn_noreq", {dmem_read, dmem_write}, 0);
      chk("dn_rdata", rdata, exp_rdata);
    end
    next_cycle();
    mem_read  = 4'h0;
    mem_write = 3'h0;
    dmem_ack  = 1'b0;
  endtask

  task automatic idle_cycle();
    mem_read  = {1'b0, 3'($urandom)};
    mem_write = {1'b0, 2'($urandom)};
    addr      = $urandom;
    dmem_ack  = 1'($urandom_range(0, 1));
    #3;
    chk("idle_busy", busy_wait, 0);
    chk("idle_done", done, 0);
    chk("idle_noreq", {dmem_read, dmem_write}, 0);
    chk("idle_rdata", rdata, exp_rdata);
    next_cycle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] legal_ld [5];
    bit          st;
    logic [2:0]  f3;
    logic [31:0] a;
    int          k;
    legal_ld = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    // Reset state
    reset = 1'b1; mem_read = 4'h0; mem_write = 3'h0; addr = 32'h0;
    wdata = 32'h0; dmem_rdata = 32'h0; dmem_ack = 1'b0;
    exp_rdata = 32'h0;
    #3;
    chk("rst_rdata", rdata, 0);
    chk("rst_flags", {done, mem_fault, busy_wait, dmem_read, dmem_write}, 0);
    chk("rst_addr", dmem_addr, 0);
    chk("rst_be", dmem_byte_en, 0);
    chk("rst_wdata", dmem_wdata, 0);
    next_cycle();
    reset = 1'b0;

    // LW 0x100 with ack three cycles after the request
    run_txn(1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 3);
    // LB / LBU at lane 3
    run_txn(1'b0, 3'b000, 32'h103, 32'h0, 32'h80AA55CC, 1);
    chk("lb_sext", rdata, 32'hFFFFFF80);
    run_txn(1'b0, 3'b100, 32'h103, 32'h0, 32'h80AA55CC, 2);
    chk("lbu_zext", rdata, 32'h00000080);
    // SH to upper half: lanes 1100, replicated data, rdata kept
    run_txn(1'b1, 3'b001, 32'h202, 32'h1234ABCD, 32'h0, 2);
    chk("sh_keep", rdata, 32'h00000080);
    idle_cycle();
    // Misaligned LW and SH
    run_txn(1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 1);
    run_txn(1'b1, 3'b001, 32'h301, 32'h5555, 32'h0, 1);
    // Illegal sizes
    run_txn(1'b0, 3'b110, 32'h400, 32'h0, 32'h0, 1);
    run_txn(1'b1, 3'b011, 32'h400, 32'h0, 32'h0, 1);
    // Ack never arrives: timeout
    run_txn(1'b0, 3'b010, 32'h104, 32'h0, 32'h0, 1000);
    // Ack exactly on the last allowed cycle still completes normally
    run_txn(1'b0, 3'b001, 32'h106, 32'h0, 32'h9abc1234, TMO + 1);

    // Reset in the middle of an access
    run_txn(1'b0, 3'b010, 32'h400, 32'h0, 32'h11223344, 2);
    mem_read = 4'b1010; mem_write = 3'b000; addr = 32'h500;
    #3;
    chk("mr_busy0", busy_wait, 1);
    next_cycle();
    #3;
    chk("mr_read1", dmem_read, 1);
    #1;
    reset = 1'b1;
    #1;
    chk("mr_read0", dmem_read, 0);
    chk("mr_busy", busy_wait, 0);
    chk("mr_rdata", rdata, 0);
    next_cycle();
    reset = 1'b0; mem_read = 4'h0;
    exp_rdata = 32'h0;
    idle_cycle();
    run_txn(1'b0, 3'b010, 32'h500, 32'h0, 32'hCAFEF00D, 2);

    // Randomized traffic
    for (int t = 0; t < 60; t++) begin
      st = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0)
        f3 = st ? {1'b0, 2'($urandom_range(0, 2))} : legal_ld[$urandom_range(0, 4)];
      a = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (f3[1:0] == 2'b01) a[0] = 1'b0;
        if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      end
      k = $urandom_range(1, 7);
      run_txn(st, f3, a, $urandom, $urandom, k);
      if ($urandom_range(0, 2) == 0) idle_cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
